// File: rtl/fg_shape_gen_if.sv
// Signal bundle for fg_shape_gen: timebase, strobe, shape configuration and
// the registered waveform output.
interface fg_shape_gen_if #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
);
    logic                         enable_i;
    logic                         strb_data_valid_i;
    logic [COUNTER_BITWIDTH-1:0]  counterValue_i;
    logic [COUNTER_BITWIDTH-1:0]  counter_i;
    logic                         cfg_load_i;
    logic [1:0]                   mode_i;
    logic [COUNTER_BITWIDTH-1:0]  ON_counter_i;
    logic [WAVEFORM_BITWIDTH-1:0] k_rise_i;
    logic [WAVEFORM_BITWIDTH-1:0] k_fall_i;
    logic [WAVEFORM_BITWIDTH-1:0] amplitude_i;
    logic [WAVEFORM_BITWIDTH-1:0] offset_i;
    logic                         invert_i;
    logic [WAVEFORM_BITWIDTH-1:0] out_o;
    logic                         strb_data_valid_o;
    logic [1:0]                   state_o;
    logic                         cfg_pending_o;

    modport master (
        output enable_i, strb_data_valid_i, counterValue_i, counter_i,
        output cfg_load_i, mode_i, ON_counter_i, k_rise_i, k_fall_i,
        output amplitude_i, offset_i, invert_i,
        input  out_o, strb_data_valid_o, state_o, cfg_pending_o
    );

    modport slave (
        input  enable_i, strb_data_valid_i, counterValue_i, counter_i,
        input  cfg_load_i, mode_i, ON_counter_i, k_rise_i, k_fall_i,
        input  amplitude_i, offset_i, invert_i,
        output out_o, strb_data_valid_o, state_o, cfg_pending_o
    );
endinterface

// File: rtl/fg_shape_gen.sv
// Strobe-driven per-period envelope generator (trapezoid, ramp-hold, square,
// triangle) with shadowed configuration and a saturating invert/offset stage.
module fg_shape_gen #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    fg_shape_gen_if.slave bus
);

    localparam int CW = COUNTER_BITWIDTH;
    localparam int WW = WAVEFORM_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_TRAPEZOID = 2'd0,
        MODE_RAMP_HOLD = 2'd1,
        MODE_SQUARE    = 2'd2,
        MODE_TRIANGLE  = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e         mode;
        logic [CW-1:0] on_counter;
        logic [WW-1:0] k_rise;
        logic [WW-1:0] k_fall;
        logic [WW-1:0] amp;
        logic [WW-1:0] offset;
        logic          invert;
    } cfg_t;

    function automatic logic [WW-1:0] rise_step(input logic [WW-1:0] v,
                                                input logic [WW-1:0] k,
                                                input logic [WW-1:0] a);
        logic [WW:0] sum;
        sum = {1'b0, v} + {1'b0, k};
        if (sum[WW] || (sum[WW-1:0] > a)) begin
            return a;
        end else begin
            return sum[WW-1:0];
        end
    endfunction

    function automatic logic [WW-1:0] fall_step(input logic [WW-1:0] v,
                                                input logic [WW-1:0] k);
        if (k > v) begin
            return {WW{1'b0}};
        end else begin
            return v - k;
        end
    endfunction

    function automatic logic [WW-1:0] shape_out(input logic [WW-1:0] v,
                                                input logic          inv,
                                                input logic [WW-1:0] a,
                                                input logic [WW-1:0] off);
        logic [WW-1:0] p;
        logic [WW:0]   s;
        if (inv) begin
            p = a - v;
        end else begin
            p = v;
        end
        s = {1'b0, off} + {1'b0, p};
        if (s[WW]) begin
            return {WW{1'b1}};
        end else begin
            return s[WW-1:0];
        end
    endfunction

    cfg_t          cfg_q, cfg_d;
    cfg_t          shadow_q, shadow_d;
    cfg_t          cfg_in_s;
    logic          pending_q, pending_d;
    state_e        state_q, state_d;
    state_e        shape_next_s;
    logic [WW-1:0] val_q, val_d;
    logic [WW-1:0] step_val_s;
    logic          vld_q, vld_d;
    logic [WW-1:0] out_q, out_d;
    logic          out_vld_q, out_vld_d;
    logic          started_q, started_d;

    logic strobe_s, restart_s, apply_s;
    logic at_on_s, at_end_s, at_amp_s, at_zero_s;

    assign strobe_s  = bus.enable_i & bus.strb_data_valid_i;
    assign restart_s = strobe_s & (bus.counterValue_i == {CW{1'b0}});
    assign apply_s   = restart_s | ~bus.enable_i;

    assign at_on_s   = (bus.counterValue_i == cfg_q.on_counter);
    assign at_end_s  = (bus.counterValue_i == bus.counter_i);
    assign at_amp_s  = (val_q == cfg_q.amp);
    assign at_zero_s = (val_q == {WW{1'b0}});

    // Shadow capture and apply; a load on an apply cycle goes straight to active.
    always_comb begin
        cfg_in_s.mode       = mode_e'(bus.mode_i);
        cfg_in_s.on_counter = bus.ON_counter_i;
        cfg_in_s.k_rise     = bus.k_rise_i;
        cfg_in_s.k_fall     = bus.k_fall_i;
        cfg_in_s.amp        = bus.amplitude_i;
        cfg_in_s.offset     = bus.offset_i;
        cfg_in_s.invert     = bus.invert_i;
        cfg_d     = cfg_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (apply_s) begin
            if (bus.cfg_load_i) begin
                cfg_d = cfg_in_s;
            end else if (pending_q) begin
                cfg_d = shadow_q;
            end else begin
                cfg_d = cfg_q;
            end
            pending_d = 1'b0;
        end else if (bus.cfg_load_i) begin
            shadow_d  = cfg_in_s;
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Envelope-mode transitions on a non-restart strobe.
    always_comb begin
        shape_next_s = state_q;
        case (state_q)
            ST_RISE: begin
                case (cfg_q.mode)
                    MODE_TRAPEZOID: begin
                        if (at_on_s) begin
                            shape_next_s = ST_FALL;
                        end else if (at_amp_s) begin
                            shape_next_s = ST_ON;
                        end else if (at_end_s) begin
                            shape_next_s = ST_IDLE;
                        end else begin
                            shape_next_s = ST_RISE;
                        end
                    end
                    MODE_RAMP_HOLD: shape_next_s = at_amp_s ? ST_ON : ST_RISE;
                    MODE_TRIANGLE:  shape_next_s = at_amp_s ? ST_FALL : ST_RISE;
                    default:        shape_next_s = ST_RISE;
                endcase
            end
            ST_ON: begin
                case (cfg_q.mode)
                    MODE_TRAPEZOID: shape_next_s = at_on_s ? ST_FALL : ST_ON;
                    MODE_TRIANGLE:  shape_next_s = ST_FALL;
                    default:        shape_next_s = ST_ON;
                endcase
            end
            ST_FALL: shape_next_s = at_zero_s ? ST_IDLE : ST_FALL;
            ST_IDLE: shape_next_s = ST_IDLE;
            default: shape_next_s = ST_IDLE;
        endcase
    end

    // Value step follows the state held before this strobe's transition.
    always_comb begin
        step_val_s = val_q;
        case (state_q)
            ST_RISE: step_val_s = rise_step(val_q, cfg_q.k_rise, cfg_q.amp);
            ST_FALL: step_val_s = fall_step(val_q, cfg_q.k_fall);
            ST_ON:   step_val_s = val_q;
            ST_IDLE: step_val_s = {WW{1'b0}};
            default: step_val_s = {WW{1'b0}};
        endcase
    end

    // Next state and value: disable, restart, regular strobe, or hold.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        if (!bus.enable_i) begin
            state_d = ST_IDLE;
            val_d   = {WW{1'b0}};
        end else if (restart_s) begin
            if (cfg_d.mode == MODE_SQUARE) begin
                if (cfg_d.on_counter == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                    val_d   = {WW{1'b0}};
                end else begin
                    state_d = ST_ON;
                    val_d   = cfg_d.amp;
                end
            end else begin
                state_d = ST_RISE;
                val_d   = {WW{1'b0}};
            end
        end else if (strobe_s) begin
            if (cfg_q.mode == MODE_SQUARE) begin
                if (bus.counterValue_i < cfg_q.on_counter) begin
                    state_d = ST_ON;
                    val_d   = cfg_q.amp;
                end else begin
                    state_d = ST_IDLE;
                    val_d   = {WW{1'b0}};
                end
            end else begin
                state_d = shape_next_s;
                val_d   = step_val_s;
            end
        end else begin
            state_d = state_q;
            val_d   = val_q;
        end
    end

    // Output stage; stays at zero after reset until the first period restart.
    always_comb begin
        vld_d     = strobe_s;
        started_d = started_q | restart_s;
        out_vld_d = 1'b0;
        out_d     = out_q;
        if (!bus.enable_i) begin
            out_d     = {WW{1'b0}};
            out_vld_d = 1'b0;
        end else if (vld_q) begin
            out_vld_d = 1'b1;
            if (started_q) begin
                out_d = shape_out(val_q, cfg_q.invert, cfg_q.amp, cfg_q.offset);
            end else begin
                out_d = {WW{1'b0}};
            end
        end else begin
            out_d     = out_q;
            out_vld_d = 1'b0;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // Envelope state and value registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            val_q     <= {WW{1'b0}};
            vld_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            vld_q     <= vld_d;
            started_q <= started_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_q     <= {WW{1'b0}};
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.out_o             = out_q;
    assign bus.strb_data_valid_o = out_vld_q;
    assign bus.state_o           = state_q;
    assign bus.cfg_pending_o     = pending_q;

endmodule

// File: tb/tb_fg_shape_gen.sv
// Scoreboard bench for fg_shape_gen: expected samples are queued at strobe time
// and compared whenever the DUT flags an output sample.
module tb_fg_shape_gen;

    localparam int CB = 16;
    localparam int WB = 8;

    logic          clk;
    logic          rstn;
    int            checks;
    int            errors;
    logic [WB-1:0] exp_q[$];
    logic [WB-1:0] mon_exp;

    fg_shape_gen_if #(.COUNTER_BITWIDTH(CB), .WAVEFORM_BITWIDTH(WB)) bus ();

    fg_shape_gen #(.COUNTER_BITWIDTH(CB), .WAVEFORM_BITWIDTH(WB)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every flagged sample must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.strb_data_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got sample %0d, expected no sample", bus.out_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.out_o !== mon_exp) begin
                    errors++;
                    $display("FAIL out_sample: got %0d expected %0d", bus.out_o, mon_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.strb_data_valid_i = 1'b0;
        bus.cfg_load_i        = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [CB-1:0] on,
                           input logic [WB-1:0] kr, input logic [WB-1:0] kf,
                           input logic [WB-1:0] amp, input logic [WB-1:0] off,
                           input logic inv);
        bus.mode_i       = mode;
        bus.ON_counter_i = on;
        bus.k_rise_i     = kr;
        bus.k_fall_i     = kf;
        bus.amplitude_i  = amp;
        bus.offset_i     = off;
        bus.invert_i     = inv;
    endtask

    task automatic load_cfg_disabled(input logic [1:0] mode, input logic [CB-1:0] on,
                                     input logic [WB-1:0] kr, input logic [WB-1:0] kf,
                                     input logic [WB-1:0] amp, input logic [WB-1:0] off,
                                     input logic inv);
        set_cfg(mode, on, kr, kf, amp, off, inv);
        bus.enable_i          = 1'b0;
        bus.strb_data_valid_i = 1'b0;
        bus.cfg_load_i        = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_load_i = 1'b0;
        checks++;
        if (bus.cfg_pending_o !== 1'b0) begin
            errors++;
            $display("FAIL load_disabled_pending: got %0b expected 0", bus.cfg_pending_o);
        end
    endtask

    task automatic strobe(input logic [CB-1:0] cv, input logic [WB-1:0] exp_out);
        bus.enable_i          = 1'b1;
        bus.strb_data_valid_i = 1'b1;
        bus.counterValue_i    = cv;
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        bus.strb_data_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d samples missing, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle(2);
        checks++;
        if ({bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o} !== {WB'(0), 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got out=%0d vld=%0b st=%0d pend=%0b expected all 0",
                     bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o);
        end
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic test_trapezoid();
        int vals [10] = '{0, 40, 80, 100, 100, 100, 100, 70, 40, 10};
        int sts  [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3};
        bus.counter_i = CB'(9);
        load_cfg_disabled(2'd0, CB'(6), 8'd40, 8'd30, 8'd100, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            strobe(CB'(i), WB'(vals[i]));
            checks++;
            if (bus.state_o !== 2'(sts[i])) begin
                errors++;
                $display("FAIL trap_state[%0d]: got %0d expected %0d", i, bus.state_o, sts[i]);
            end
        end
        strobe(CB'(0), 8'd0);
        checks++;
        if (bus.state_o !== 2'd1) begin
            errors++;
            $display("FAIL trap_restart_state: got %0d expected 1", bus.state_o);
        end
        drain("trapezoid");
    endtask

    task automatic test_triangle();
        int vals [10] = '{0, 50, 100, 100, 75, 50, 25, 0, 0, 0};
        int sts  [10] = '{1, 1, 1, 3, 3, 3, 3, 3, 0, 0};
        bus.counter_i = CB'(15);
        load_cfg_disabled(2'd3, CB'(2), 8'd50, 8'd25, 8'd100, 8'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            strobe(CB'(i), WB'(vals[i]));
            checks++;
            if (bus.state_o !== 2'(sts[i])) begin
                errors++;
                $display("FAIL tri_state[%0d]: got %0d expected %0d", i, bus.state_o, sts[i]);
            end
        end
        strobe(CB'(0), 8'd0);
        drain("triangle");
    endtask

    task automatic test_square();
        int outs [8] = '{60, 60, 60, 255, 255, 255, 255, 255};
        int sts  [8] = '{2, 2, 2, 0, 0, 0, 0, 0};
        bus.counter_i = CB'(7);
        load_cfg_disabled(2'd2, CB'(3), 8'd5, 8'd5, 8'd200, 8'd60, 1'b1);
        for (int i = 0; i < 8; i++) begin
            strobe(CB'(i), WB'(outs[i]));
            checks++;
            if (bus.state_o !== 2'(sts[i])) begin
                errors++;
                $display("FAIL sq_state[%0d]: got %0d expected %0d", i, bus.state_o, sts[i]);
            end
        end
        drain("square");
    endtask

    task automatic test_cfg_pending();
        int outs2 [10] = '{0, 40, 50, 50, 50, 50, 50, 20, 0, 0};
        bus.counter_i = CB'(9);
        load_cfg_disabled(2'd0, CB'(6), 8'd40, 8'd30, 8'd100, 8'd0, 1'b0);
        strobe(CB'(0), 8'd0);
        strobe(CB'(1), 8'd40);
        strobe(CB'(2), 8'd80);
        strobe(CB'(3), 8'd100);
        set_cfg(2'd0, CB'(6), 8'd40, 8'd30, 8'd50, 8'd0, 1'b0);
        bus.cfg_load_i = 1'b1;
        strobe(CB'(4), 8'd100);
        bus.cfg_load_i = 1'b0;
        checks++;
        if (bus.cfg_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_set: got %0b expected 1", bus.cfg_pending_o);
        end
        strobe(CB'(5), 8'd100);
        set_cfg(2'd0, CB'(6), 8'd40, 8'd30, 8'd77, 8'd0, 1'b0);
        bus.cfg_load_i = 1'b1;
        strobe(CB'(6), 8'd100);
        set_cfg(2'd0, CB'(6), 8'd40, 8'd30, 8'd50, 8'd0, 1'b0);
        strobe(CB'(7), 8'd70);
        bus.cfg_load_i = 1'b0;
        strobe(CB'(8), 8'd40);
        strobe(CB'(9), 8'd10);
        checks++;
        if (bus.cfg_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_hold: got %0b expected 1", bus.cfg_pending_o);
        end
        for (int i = 0; i < 10; i++) begin
            strobe(CB'(i), WB'(outs2[i]));
            if (i == 0) begin
                checks++;
                if (bus.cfg_pending_o !== 1'b0) begin
                    errors++;
                    $display("FAIL pend_clear: got %0b expected 0", bus.cfg_pending_o);
                end
            end
        end
        drain("cfg_pending");
    endtask

    task automatic test_saturation();
        bus.counter_i = CB'(20);
        load_cfg_disabled(2'd0, CB'(15), 8'd200, 8'd1, 8'd250, 8'd10, 1'b0);
        strobe(CB'(0), 8'd10);
        idle(1);
        strobe(CB'(1), 8'd210);
        idle(1);
        strobe(CB'(2), 8'd255);
        idle(1);
        strobe(CB'(3), 8'd255);
        checks++;
        if (bus.state_o !== 2'd2) begin
            errors++;
            $display("FAIL sat_state: got %0d expected 2", bus.state_o);
        end
        drain("saturation");
    endtask

    task automatic test_boundaries();
        bus.counter_i = CB'(20);
        load_cfg_disabled(2'd0, CB'(10), 8'd40, 8'd30, 8'd0, 8'd0, 1'b0);
        strobe(CB'(0), 8'd0);
        strobe(CB'(1), 8'd0);
        checks++;
        if (bus.state_o !== 2'd2) begin
            errors++;
            $display("FAIL amp0_state: got %0d expected 2", bus.state_o);
        end
        drain("amp0");
        bus.counter_i = CB'(4);
        load_cfg_disabled(2'd0, CB'(10), 8'd0, 8'd30, 8'd100, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            strobe(CB'(i), 8'd0);
            checks++;
            if (bus.state_o !== ((i == 4) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL krise0_state[%0d]: got %0d expected %0d", i, bus.state_o, (i == 4) ? 0 : 1);
            end
        end
        drain("krise0");
        load_cfg_disabled(2'd2, CB'(0), 8'd5, 8'd5, 8'd200, 8'd0, 1'b0);
        strobe(CB'(0), 8'd0);
        checks++;
        if (bus.state_o !== 2'd0) begin
            errors++;
            $display("FAIL sq_on0_state: got %0d expected 0", bus.state_o);
        end
        drain("sq_on0");
    endtask

    task automatic test_reset_midrise();
        bus.counter_i = CB'(9);
        load_cfg_disabled(2'd0, CB'(6), 8'd40, 8'd30, 8'd100, 8'd0, 1'b0);
        strobe(CB'(0), 8'd0);
        strobe(CB'(1), 8'd40);
        strobe(CB'(2), 8'd80);
        drain("pre_reset");
        checks++;
        if (bus.state_o !== 2'd1 || bus.out_o !== 8'd80) begin
            errors++;
            $display("FAIL pre_reset: got st=%0d out=%0d expected st=1 out=80", bus.state_o, bus.out_o);
        end
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o} !== {WB'(0), 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got out=%0d vld=%0b st=%0d pend=%0b expected all 0",
                     bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        load_cfg_disabled(2'd0, CB'(6), 8'd40, 8'd30, 8'd100, 8'd20, 1'b0);
        strobe(CB'(5), 8'd0);
        strobe(CB'(6), 8'd0);
        strobe(CB'(0), 8'd20);
        strobe(CB'(1), 8'd60);
        set_cfg(2'd0, CB'(6), 8'd40, 8'd30, 8'd50, 8'd20, 1'b0);
        bus.cfg_load_i        = 1'b1;
        bus.strb_data_valid_i = 1'b1;
        bus.counterValue_i    = CB'(2);
        @(posedge clk);
        #1;
        bus.cfg_load_i        = 1'b0;
        bus.strb_data_valid_i = 1'b0;
        checks++;
        if (bus.cfg_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL dis_pend_set: got %0b expected 1", bus.cfg_pending_o);
        end
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o} !== {WB'(0), 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL disable: got out=%0d vld=%0b st=%0d pend=%0b expected all 0",
                     bus.out_o, bus.strb_data_valid_o, bus.state_o, bus.cfg_pending_o);
        end
        bus.strb_data_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.strb_data_valid_i = 1'b0;
        drain("disable");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        bus.enable_i          = 1'b0;
        bus.strb_data_valid_i = 1'b0;
        bus.counterValue_i    = '0;
        bus.counter_i         = '0;
        bus.cfg_load_i        = 1'b0;
        set_cfg(2'd0, '0, '0, '0, '0, '0, 1'b0);
        test_reset();
        test_trapezoid();
        test_triangle();
        test_square();
        test_cfg_pending();
        test_saturation();
        test_boundaries();
        test_reset_midrise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
